// File: rtl/flag_branch_unit.sv
// flag_branch_unit: holds the architectural NZCV flags and resolves the
// B.cond, CBZ and CBNZ instructions in ID. Flags from a flag-setting
// instruction in EX are forwarded, so SUBS followed directly by B.cond
// resolves without a stall. Branch outcomes are registered for fetch.
// Optional branch statistics counters: define FLAG_BR_STATS_EN.
module flag_branch_unit #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_set_flags,
  input  logic              alu_neg,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              id_valid,
  input  logic              id_br_cond,
  input  logic              id_cbz,
  input  logic              id_cbnz,
  input  logic [3:0]        id_cond,
  input  logic              id_reg_zero,
  output logic [3:0]        flags,
  output logic              br_taken,
  output logic              br_resolved,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken
);

  logic [3:0] aluFlags;
  logic [3:0] effFlags;
  logic       exFwd;
  logic       flagWrite;
  logic       flagN, flagZ, flagC, flagV;
  logic       condPass;
  logic       condTrue;
  logic       eval;

  assign aluFlags  = {alu_neg, alu_zero, alu_carry, alu_ovf};
  // Forwarding ignores stall; only the decision is held back by stall.
  assign exFwd     = ex_valid & ex_set_flags & ~flush;
  assign flagWrite = exFwd & ~stall;
  assign effFlags  = exFwd ? aluFlags : flags;
  assign {flagN, flagZ, flagC, flagV} = effFlags;
  assign eval = id_valid & (id_br_cond | id_cbz | id_cbnz) & ~stall & ~flush;

  // Evaluate the ARM condition code against the effective flags.
  always_comb begin
    condPass = 1'b0;
    case (id_cond)
      4'h0: condPass = flagZ;
      4'h1: condPass = ~flagZ;
      4'h2: condPass = flagC;
      4'h3: condPass = ~flagC;
      4'h4: condPass = flagN;
      4'h5: condPass = ~flagN;
      4'h6: condPass = flagV;
      4'h7: condPass = ~flagV;
      4'h8: condPass = flagC & ~flagZ;
      4'h9: condPass = ~flagC | flagZ;
      4'hA: condPass = (flagN == flagV);
      4'hB: condPass = (flagN != flagV);
      4'hC: condPass = ~flagZ & (flagN == flagV);
      4'hD: condPass = flagZ | (flagN != flagV);
      default: condPass = 1'b1;
    endcase
  end

  // Branch type priority: CBZ, then CBNZ, then B.cond.
  always_comb begin
    condTrue = 1'b0;
    if (id_cbz)
      condTrue = id_reg_zero;
    else if (id_cbnz)
      condTrue = ~id_reg_zero;
    else if (id_br_cond)
      condTrue = condPass;
  end

  // Flag register and registered branch decision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags       <= 4'b0000;
      br_taken    <= 1'b0;
      br_resolved <= 1'b0;
    end else begin
      if (flagWrite)
        flags <= aluFlags;
      br_resolved <= eval;
      br_taken    <= eval & condTrue;
    end
  end

`ifdef FLAG_BR_STATS_EN
  // Resolved and taken branch counters; wrap naturally at 2^STAT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (eval)
        stat_branches <= stat_branches + 1'b1;
      if (eval & condTrue)
        stat_taken <= stat_taken + 1'b1;
    end
  end
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the flag register,
// forwarding, condition codes and optional statistics.
module tb_flag_branch_unit;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset, stall, flush, ex_valid, ex_set_flags;
  logic alu_neg, alu_zero, alu_carry, alu_ovf;
  logic id_valid, id_br_cond, id_cbz, id_cbnz, id_reg_zero;
  logic [3:0] id_cond;
  logic [3:0] flags;
  logic br_taken, br_resolved;
  logic [SW-1:0] stat_branches, stat_taken;

  int nPass = 0;
  int nTotal = 0;

  // model state
  logic [3:0] mFlags = 4'b0000;
  int mBranches = 0;
  int mTaken = 0;

  flag_branch_unit #(.STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .id_valid(id_valid), .id_br_cond(id_br_cond), .id_cbz(id_cbz), .id_cbnz(id_cbnz),
    .id_cond(id_cond), .id_reg_zero(id_reg_zero),
    .flags(flags), .br_taken(br_taken), .br_resolved(br_resolved),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTotal++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ARM scheme: cond[3:1] picks a base test, cond[0] inverts it (except AL/NV).
  function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] != 3'd7 && c[0]) ? !base : base;
  endfunction

  task automatic idle();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_set_flags = 1'b0;
    {alu_neg, alu_zero, alu_carry, alu_ovf} = 4'b0000;
    id_valid = 1'b0; id_br_cond = 1'b0; id_cbz = 1'b0; id_cbnz = 1'b0;
    id_cond = 4'h0; id_reg_zero = 1'b0;
  endtask

  // Apply current inputs for one clock and compare against the model.
  task automatic step();
    logic [3:0] alu, fwd, nextFlags;
    bit isBr, ev, tk, expT, expR;
    alu = {alu_neg, alu_zero, alu_carry, alu_ovf};
    fwd = (ex_valid && ex_set_flags && !flush) ? alu : mFlags;
    isBr = id_valid && (id_br_cond || id_cbz || id_cbnz);
    ev = isBr && !stall && !flush;
    if (id_cbz) tk = id_reg_zero;
    else if (id_cbnz) tk = !id_reg_zero;
    else tk = condHolds(id_cond, fwd);
    if (!reset) begin
      nextFlags = 4'b0000; expR = 0; expT = 0; mBranches = 0; mTaken = 0;
    end else begin
      nextFlags = (ex_valid && ex_set_flags && !stall && !flush) ? alu : mFlags;
      expR = ev; expT = ev && tk;
      if (ev) mBranches = (mBranches + 1) % (1 << SW);
      if (ev && tk) mTaken = (mTaken + 1) % (1 << SW);
    end
    mFlags = nextFlags;
    @(posedge clk); #1;
    checkVal("flags", 32'(flags), 32'(mFlags));
    checkVal("br_taken", 32'(br_taken), 32'(expT));
    checkVal("br_resolved", 32'(br_resolved), 32'(expR));
`ifdef FLAG_BR_STATS_EN
    checkVal("stat_branches", 32'(stat_branches), 32'(mBranches));
    checkVal("stat_taken", 32'(stat_taken), 32'(mTaken));
`else
    checkVal("stat_branches", 32'(stat_branches), 32'd0);
    checkVal("stat_taken", 32'(stat_taken), 32'd0);
`endif
  endtask

  task automatic randomInputs();
    {stall, flush, ex_valid, ex_set_flags} = 4'($urandom);
    {alu_neg, alu_zero, alu_carry, alu_ovf} = 4'($urandom);
    {id_valid, id_br_cond, id_cbz, id_cbnz, id_reg_zero} = 5'($urandom);
    id_cond = 4'($urandom);
    if ($urandom_range(3) != 0) stall = 1'b0;
    if ($urandom_range(3) != 0) flush = 1'b0;
  endtask

  initial begin
    idle();
    // reset held two cycles with toggling inputs
    for (int i = 0; i < 2; i++) begin
      randomInputs();
      reset = 1'b0;
      step();
    end
    checkVal("rst_flags", 32'(flags), 32'd0);
    checkVal("rst_taken", 32'(br_taken), 32'd0);

    // forwarding: SUBS Z=1 in EX with B.EQ in ID
    idle();
    ex_valid = 1; ex_set_flags = 1; alu_zero = 1;
    id_valid = 1; id_br_cond = 1; id_cond = 4'h0;
    step();
    checkVal("fwd_beq_taken", 32'(br_taken), 32'd1);
    checkVal("fwd_beq_flags", 32'(flags), 32'b0100);
    // same with B.NE after resetting flags
    idle(); reset = 0; step();
    idle();
    ex_valid = 1; ex_set_flags = 1; alu_zero = 1;
    id_valid = 1; id_br_cond = 1; id_cond = 4'h1;
    step();
    checkVal("fwd_bne_taken", 32'(br_taken), 32'd0);

    // CBZ / CBNZ with reg zero; flags untouched
    idle(); id_valid = 1; id_cbz = 1; id_reg_zero = 1; step();
    checkVal("cbz_taken", 32'(br_taken), 32'd1);
    idle(); id_valid = 1; id_cbnz = 1; id_reg_zero = 1; step();
    checkVal("cbnz_taken", 32'(br_taken), 32'd0);
    checkVal("cb_flags", 32'(flags), 32'b0100);

    // signed conditions after ADDS N=1 V=0
    idle(); ex_valid = 1; ex_set_flags = 1; alu_neg = 1; step();
    idle(); id_valid = 1; id_br_cond = 1; id_cond = 4'hB; step();
    checkVal("blt_taken", 32'(br_taken), 32'd1);
    id_cond = 4'hA; step();
    checkVal("bge_taken", 32'(br_taken), 32'd0);
    id_cond = 4'hC; step();
    checkVal("bgt_taken", 32'(br_taken), 32'd0);

    // stall then flush then release
    idle(); ex_valid = 1; ex_set_flags = 1; alu_zero = 1;
    id_valid = 1; id_br_cond = 1; id_cond = 4'h0;
    stall = 1; step();
    checkVal("stall_flags", 32'(flags), 32'b1000);
    checkVal("stall_resolved", 32'(br_resolved), 32'd0);
    stall = 0; flush = 1; step();
    checkVal("flush_flags", 32'(flags), 32'b1000);
    flush = 1; stall = 1; step();
    checkVal("stflush_flags", 32'(flags), 32'b1000);
    stall = 0; flush = 0; step();
    checkVal("release_flags", 32'(flags), 32'b0100);
    checkVal("release_taken", 32'(br_taken), 32'd1);

    // 17 taken branches from clean reset: counters wrap at 4 bits
    idle(); reset = 0; step();
    idle(); id_valid = 1; id_br_cond = 1; id_cond = 4'hE;
    for (int i = 0; i < 17; i++) step();
`ifdef FLAG_BR_STATS_EN
    checkVal("wrap_branches", 32'(stat_branches), 32'd1);
    checkVal("wrap_taken", 32'(stat_taken), 32'd1);
`else
    checkVal("wrap_branches", 32'(stat_branches), 32'd0);
    checkVal("wrap_taken", 32'(stat_taken), 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      randomInputs();
      reset = ($urandom_range(39) != 0);
      step();
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumes the per-result zero flag (plus N/C/V) produced by the EX-stage ALU and holds the architectural NZCV flag register.
- Resolves B.cond, CBZ and CBNZ for the instruction in ID.
- Forwards flags from a flag-setting instruction currently in EX, so a back-to-back SUBS/B.cond pair resolves without a stall.
- Drives a registered branch-taken decision to the PC/fetch logic.

Parameters:
- STAT_W, 32, width of the optional branch statistics counters.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset; asserted when 0
- stall  input  1  pipeline stall; freezes flag register and suppresses decisions
- flush  input  1  kills the EX and ID instructions this cycle
- ex_valid  input  1  EX stage holds a valid instruction
- ex_set_flags  input  1  EX instruction updates flags (ADDS/SUBS/ANDS)
- alu_neg  input  1  ALU result bit 63
- alu_zero  input  1  zero flag of ALU result
- alu_carry  input  1  ALU carry out
- alu_ovf  input  1  ALU signed overflow
- id_valid  input  1  ID stage holds a valid instruction
- id_br_cond  input  1  ID instruction is B.cond
- id_cbz  input  1  ID instruction is CBZ
- id_cbnz  input  1  ID instruction is CBNZ
- id_cond  input  4  B.cond condition code
- id_reg_zero  input  1  zero flag of the (forwarded) CBZ/CBNZ register operand
- flags  output  4  registered NZCV, bit3=N, bit2=Z, bit1=C, bit0=V
- br_taken  output  1  registered branch decision, one cycle after ID evaluation
- br_resolved  output  1  registered: a branch was evaluated (taken or not)
- stat_branches  output  STAT_W  resolved-branch count (optional feature)
- stat_taken  output  STAT_W  taken-branch count (optional feature)

Behaviour:
- Reset (reset==0 at clk edge): flags=4'b0000, br_taken=0, br_resolved=0, stat counters=0. Reset overrides stall and flush, including mid-branch.
- Flag write: at clk edge, if ex_valid & ex_set_flags & !stall & !flush, then flags <= {alu_neg, alu_zero, alu_carry, alu_ovf}; otherwise flags hold.
- Forwarding: eff = (ex_valid & ex_set_flags & !flush) ? ALU flags : flags. Combinational, same cycle. Forwarding is not gated by stall; the decision itself is suppressed under stall.
- Condition codes (ARM): 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 1.
- Branch type priority: CBZ > CBNZ > B.cond. Multiple type bits set is illegal; priority defines the result.
  - CBZ is taken when id_reg_zero==1.
  - CBNZ is taken when id_reg_zero==0.
  - CBZ/CBNZ ignore the flags.
- eval = id_valid & (id_br_cond|id_cbz|id_cbnz) & !stall & !flush.
- At clk edge: br_resolved <= eval; br_taken <= eval & cond_true. Latency is 1 cycle from ID presentation.
- Under stall: br_taken and br_resolved are 0 next cycle. The ID instruction re-evaluates when the stall releases, using whatever flags/forwarding apply then.
- Under flush: no flag write, br_taken=0, br_resolved=0 next cycle.
- Simultaneous stall and flush: flush semantics apply; both produce no update.

Optional Feature:
- Macro FLAG_BR_STATS_EN.
- Defined:
  - stat_branches increments when eval.
  - stat_taken increments when eval & cond_true.
  - Both are registered, wrap from 2^STAT_W-1 to 0, and clear on reset.
- Undefined: no counter logic; stat_branches and stat_taken are tied to 0.

Test Plan:
- Reset: hold reset=0 two cycles with all inputs toggling -> flags=0000, br_taken=0, br_resolved=0.
- Forwarding: EX SUBS with alu_zero=1 (flags reg 0000) while ID B.EQ (id_cond=0) -> next cycle br_taken=1, flags=0100. Repeat with id_cond=1 -> br_taken=0.
- CBZ/CBNZ: id_cbz=1, id_reg_zero=1 -> br_taken=1. id_cbnz=1, id_reg_zero=1 -> br_taken=0. Flags unchanged in both cases.
- Signed conditions: flags N=1,V=0 set by prior ADDS. B.LT (B) -> taken. B.GE (A) -> not taken. B.GT (C) -> not taken.
- Stall/flush: SUBS in EX with stall=1 -> flags unchanged, br_resolved=0. Same with flush=1 -> flags unchanged. Release -> update occurs once.
- With FLAG_BR_STATS_EN and STAT_W=4: 17 evaluated taken branches -> stat_branches=1, stat_taken=1 (wrap verified).
